// File: rtl/sum16_sched.sv
// Serial job accumulator: sums N signed operands with one shared AW-bit adder,
// skipping operands whose latched mask bit is clear, and holds the result until taken.
module sum16_sched #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [N-1:0]  i_mask,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [AW-1:0] o_out_data,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic [3:0]    o_idx
);

  // state  | meaning
  // S_IDLE | waiting for start, no job in flight
  // S_ACC  | accepting operands, one per valid beat
  // S_HOLD | result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_acc;
  logic [N-1:0]  r_mask;
  logic [3:0]    r_idx;
  logic [15:0]   w_mask_ext;
  logic [AW-1:0] w_operand;
  logic          w_last;

  assign w_mask_ext = 16'(r_mask);
  assign w_operand  = {{(AW-DW){i_in_data[DW-1]}}, i_in_data};
  assign w_last     = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_busy      = (r_state != S_IDLE);
    o_idx       = r_idx;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_ACC;
      S_ACC: begin
        o_in_ready = 1'b1;
        if (i_in_valid && w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        o_out_valid = 1'b1;
        o_out_data  = r_acc;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // idx wraps to 0 on the last beat so it already reads 0 throughout HOLD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_mask <= '0;
      r_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_mask <= i_mask;
          end
        end
        S_ACC: begin
          if (i_in_valid) begin
            if (w_mask_ext[r_idx]) r_acc <= r_acc + w_operand;
            r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum16_sched.sv
// Directed bench for sum16_sched: default build plus an AW=10 build sharing stimulus
// to exercise modulo wrap.
module tb_sum16_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] mask;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [3:0]  idx;
  logic        in_ready_w, out_valid_w, busy_w;
  logic [9:0]  out_data_w;
  logic [3:0]  idx_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ops [16];
  logic [31:0] res;
  logic [9:0]  res_w;

  sum16_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mask(mask),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_busy(busy), .o_idx(idx)
  );

  sum16_sched #(.N(16), .DW(8), .AW(10)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mask(mask),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready_w),
    .o_out_valid(out_valid_w), .o_out_data(out_data_w), .i_out_ready(out_ready),
    .o_busy(busy_w), .o_idx(idx_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One job: inputs change on negedges, outputs sampled on negedges.
  task automatic run_job(input logic [15:0] m, input bit stall, input int hold,
                         output logic [31:0] r, output logic [9:0] r_w);
    int k;
    int guard;
    logic acc_beat;
    start = 1'b1;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
    mask  = ~m;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    k = 0;
    guard = 0;
    while (k < 16 && guard < 400) begin
      chk("idx_track", {28'b0, idx}, 32'(k));
      chk("in_ready_acc", {31'b0, in_ready}, 32'd1);
      in_data  = ops[k];
      in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall) start = 1'($urandom_range(0, 1));
      acc_beat = in_valid && in_ready;
      @(negedge clk);
      if (acc_beat) k++;
      guard++;
    end
    if (guard >= 400) chk("beat_timeout", 32'(k), 32'd16);
    in_valid = 1'b0;
    start    = 1'b0;
    chk("out_valid_latency", {31'b0, out_valid}, 32'd1);
    chk("in_ready_hold", {31'b0, in_ready}, 32'd0);
    chk("idx_hold", {28'b0, idx}, 32'd0);
    r   = out_data;
    r_w = out_data_w;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h05;
      start     = 1'b1;
      @(negedge clk);
      chk("hold_stable", out_data, r);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = stall;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("out_valid_cleared", {31'b0, out_valid}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("no_queued_start", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mask = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    in_valid = 1'b1;
    in_data  = 8'h7F;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);
    chk("idle_idx", {28'b0, idx}, 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 16; i++) ops[i] = 8'(i + 1);
    run_job(16'hFFFF, 1'b0, 0, res, res_w);
    chk("full_sum", res, 32'd136);

    for (int i = 0; i < 16; i++) ops[i] = 8'h80;
    run_job(16'hFBFF, 1'b0, 1, res, res_w);
    chk("skip_sign", res, 32'hFFFFF880);

    for (int i = 0; i < 16; i++) ops[i] = 8'(i + 1);
    run_job(16'hFFFF, 1'b1, 5, res, res_w);
    chk("stall_sum", res, 32'd136);

    for (int i = 0; i < 16; i++) ops[i] = 8'h7F;
    run_job(16'h0000, 1'b0, 0, res, res_w);
    chk("zero_mask", res, 32'd0);

    run_job(16'hFFFF, 1'b0, 0, res, res_w);
    chk("wrap_wide", res, 32'h000007F0);
    chk("wrap_narrow", {22'b0, res_w}, 32'h000003F0);

    for (int i = 0; i < 16; i++) ops[i] = 8'(i + 1);
    start = 1'b1;
    mask  = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      @(negedge clk);
    end
    chk("pre_reset_idx", {28'b0, idx}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_idx", {28'b0, idx}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(16'hFFFF, 1'b0, 0, res, res_w);
    chk("after_reset_sum", res, 32'd136);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum16_sched.md
SUM16_SCHED -- requirements
Module: sum16_sched

Interface
REQ-001 Parameter N, default 16: operands per job; allowed range 2..16.
REQ-002 Parameter DW, default 8: operand width, two's-complement signed.
REQ-003 Parameter AW, default 32: accumulator and result width, two's-complement signed.
REQ-004 Clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 Rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  in  1  job request; sampled only in IDLE.
REQ-007 mask  in  N  per-index add enable; bit i=1 adds operand i; latched on an accepted start.
REQ-008 in_valid  in  1  operand stream valid.
REQ-009 in_data  in  DW  signed operand.
REQ-010 in_ready  out  1  operand accepted when in_valid && in_ready.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_data  out  AW  signed result.
REQ-013 out_ready  in  1  result accepted when out_valid && out_ready.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 idx  out  4  index of the next operand to be accepted.

Function
REQ-016 The block SHALL time-share a single AW-bit signed adder to sum one job of N serially delivered operands, one operand per accepted beat.
REQ-017 The block SHALL have three states: IDLE, ACC and HOLD.
REQ-018 IDLE: start=1 moves to ACC next edge; on that edge acc=0, idx=0, mask latched; start=0 stays in IDLE.
REQ-019 ACC: in_ready SHALL be 1; each accepted beat increments idx by 1.
REQ-020 On an accepted beat with latched mask[idx]=1, acc SHALL become acc + sign-extended in_data.
REQ-021 On an accepted beat with latched mask[idx]=0, the operand SHALL be consumed and discarded, and acc SHALL be unchanged.
REQ-022 A cycle in ACC with in_valid=0 SHALL hold acc and idx unchanged (stall, no timeout).
REQ-023 The beat accepted at idx=N-1 SHALL move the state to HOLD; out_valid SHALL be 1 the next cycle with out_data equal to the final acc (1-cycle latency from the last operand).
REQ-024 HOLD: out_valid=1 and out_data stable until out_valid && out_ready; in_ready=0; the handshake returns to IDLE next edge and clears out_valid.
REQ-025 Arithmetic SHALL wrap modulo 2^AW, with no saturation and no overflow flag.
REQ-026 start SHALL be ignored in ACC and HOLD, including the cycle HOLD exits; no queued start.
REQ-027 Changes to the mask input after the start edge SHALL not affect the running job.
REQ-028 in_ready SHALL be 0 in IDLE and HOLD; in_valid in those states SHALL be ignored and SHALL not alter acc.
REQ-029 An all-zero mask SHALL still consume N beats and produce out_data=0.
REQ-030 idx SHALL read 0 in IDLE and HOLD.

Reset
REQ-031 Rst=0 SHALL force, asynchronously, state=IDLE, acc=0, latched mask=0, idx=0, out_valid=0, in_ready=0, busy=0, out_data=0.
REQ-032 Rst asserted mid-job SHALL abort the job with no out_valid pulse; after deassertion a new start begins a clean job.
REQ-033 Reset deassertion SHALL be synchronous to Clk edges; the first start is honoured on the first edge after release.

Verification
REQ-034 Full sum: N=16, mask=16'hFFFF, operands 1..16 back-to-back -> out_valid 1 cycle after the 16th beat, out_data=136, busy high from start+1 until the handshake.
REQ-035 Skip and sign: mask=16'hFBFF (bit10=0), all operands -128 -> out_data = -1920 (32'hFFFFF880); operand at idx 10 consumed but not added.
REQ-036 Stalls and backpressure: random in_valid gaps, out_ready held 0 for 5 cycles -> same result as the gap-free run, out_data stable while waiting, start pulses during the job ignored.
REQ-037 Zero mask: mask=0, operands 127 -> 16 beats consumed, out_data=0.
REQ-038 Reset mid-job: Rst=0 after 7 beats -> all outputs at reset values immediately; next job 1..16 with a full mask -> 136.
REQ-039 Wrap: N=16, AW=10 build, all operands 127 -> out_data = 2032 mod 1024 = 1008, read as signed = -16.
